// File: rtl/cube_sqrt_unit_pkg.sv
// Shared widths, cycle counts and FSM encoding for the cube + square-root unit.
package cube_sqrt_unit_pkg;
  localparam int A_W      = 8;
  localparam int B_W      = 8;
  localparam int Y_W      = 24;
  localparam int SQRT_W   = 4;
  localparam int SQRT_CYC = 4;
  localparam int MUL_CYC  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SQRT,
    MUL1,
    MUL2,
    SUM
  } state_t;
endpackage

// File: rtl/cube_sqrt_unit_if.sv
// Request/result bundle between a controller (master) and the unit (slave).
interface cube_sqrt_unit_if;
  import cube_sqrt_unit_pkg::*;

  logic             start_i;
  logic [A_W-1:0]   a_i;
  logic [B_W-1:0]   b_i;
  logic             busy_o;
  logic [Y_W-1:0]   y_o;

  modport master (output start_i, a_i, b_i, input busy_o, y_o);
  modport slave  (input start_i, a_i, b_i, output busy_o, y_o);
endinterface

// File: rtl/cube_sqrt_unit_seq_mult.sv
// LSB-first shift-add multiplier, 16x8 -> 24 bits, one multiplier bit per cycle.
module seq_mult
  import cube_sqrt_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*A_W-1:0]     op_a,
  input  logic [A_W-1:0]       op_b,
  output logic                 busy,
  output logic [Y_W-1:0]       product
);
  logic [Y_W-1:0] acc;
  logic [Y_W-1:0] mcand;
  logic [A_W-1:0] mplier;
  logic [3:0]     cnt;
  logic [Y_W-1:0] pp;

  // The final partial product is folded in combinationally so the result is
  // usable during the last iteration cycle; once idle mplier is zero and pp=0.
  always_comb begin
    pp      = mplier[0] ? mcand : '0;
    product = acc + pp;
    busy    = (cnt != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{(Y_W-2*A_W){1'b0}}, op_a};
      mplier <= op_b;
      cnt    <= 4'(MUL_CYC);
    end else if (cnt != 4'd0) begin
      acc    <= acc + pp;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/cube_sqrt_unit.sv
// y = a^3 + floor(sqrt(b)) with a bit-serial root and one shared shift-add multiplier.
module cube_sqrt_unit
  import cube_sqrt_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  cube_sqrt_unit_if.slave bus
);
  state_t         state, state_nxt;
  logic [3:0]     cnt;
  logic           last_phase;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] x_q, r_q, m_q, t;
  logic           ge;
  logic           busy_q;
  logic [Y_W-1:0] y_q;

  logic             mult_start;
  logic [2*A_W-1:0] mult_a;
  logic [A_W-1:0]   mult_b;
  logic             mult_busy;
  logic [Y_W-1:0]   mult_p;

  assign bus.busy_o = busy_q;
  assign bus.y_o    = y_q;

  always_comb begin
    last_phase = 1'b0;
    case (state)
      SQRT:       last_phase = (cnt == 4'(SQRT_CYC-1));
      MUL1, MUL2: last_phase = (cnt == 4'(MUL_CYC-1)) && mult_busy;
      default:    last_phase = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = SQRT;
      SQRT:    if (last_phase)  state_nxt = MUL1;
      MUL1:    if (last_phase)  state_nxt = MUL2;
      MUL2:    if (last_phase)  state_nxt = SUM;
      SUM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each multiply is launched on the last edge of the preceding phase, so the
  // multiplier's 8 iterations line up exactly with the 8 cycles of MUL1/MUL2.
  always_comb begin
    mult_start = 1'b0;
    mult_a     = {{A_W{1'b0}}, a_q};
    mult_b     = a_q;
    if (state == SQRT && last_phase) begin
      mult_start = 1'b1;
    end else if (state == MUL1 && last_phase) begin
      mult_start = 1'b1;
      mult_a     = mult_p[2*A_W-1:0];
    end
  end

  always_comb begin
    t  = r_q | m_q;
    ge = (x_q >= t);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      a_q    <= '0;
      x_q    <= '0;
      r_q    <= '0;
      m_q    <= '0;
      busy_q <= 1'b0;
      y_q    <= '0;
    end else begin
      if (state == IDLE || last_phase) cnt <= '0;
      else                             cnt <= cnt + 4'd1;
      case (state)
        IDLE: if (bus.start_i) begin
          a_q    <= bus.a_i;
          x_q    <= bus.b_i;
          r_q    <= '0;
          m_q    <= 8'h40;
          busy_q <= 1'b1;
        end
        SQRT: begin
          r_q <= ge ? ((r_q >> 1) | m_q) : (r_q >> 1);
          x_q <= ge ? (x_q - t) : x_q;
          m_q <= m_q >> 2;
        end
        SUM: begin
          y_q    <= mult_p + Y_W'(r_q[SQRT_W-1:0]);
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  seq_mult u_mult (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (mult_start),
    .op_a    (mult_a),
    .op_b    (mult_b),
    .busy    (mult_busy),
    .product (mult_p)
  );
endmodule

// File: tb/tb_cube_sqrt_unit.sv
// Directed scoreboard bench for cube_sqrt_unit: results, latency, stability and reset abort.
module tb_cube_sqrt_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [23:0] exp_q[$];

  cube_sqrt_unit_if bus();

  cube_sqrt_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(int a, int b);
    int s = 0;
    while ((s + 1) * (s + 1) <= b) s++;
    return 24'(a * a * a + s);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a request for one edge; returns at the negedge after the start edge.
  task automatic start_op(int a, int b, bit hold);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 8'(a);
    bus.b_i     = 8'(b);
    exp_q.push_back(model(a, b));
    @(negedge clk);
    if (!hold) bus.start_i = 1'b0;
  endtask

  task automatic wait_done(string tag, int n0);
    int n = n0;
    logic [23:0] y0 = bus.y_o;
    bit stable = 1'b1;
    logic [23:0] e;
    while (bus.busy_o === 1'b1 && n < 60) begin
      n++;
      if (bus.y_o !== y0) stable = 1'b0;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(n), 32'd21);
    check({tag, "_y_stable"}, {31'd0, stable}, 32'd1);
    if (exp_q.size() == 0) e = 24'hFFFFFF;
    else                   e = exp_q.pop_front();
    check({tag, "_y"}, {8'd0, bus.y_o}, {8'd0, e});
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset_y", {8'd0, bus.y_o}, 32'd0);

    start_op(0, 0, 1'b0);     wait_done("zero", 0);
    start_op(15, 15, 1'b0);   wait_done("a15_b15", 0);
    start_op(255, 255, 1'b0); wait_done("max", 0);
    start_op(2, 224, 1'b0);   wait_done("b224", 0);
    start_op(2, 225, 1'b0);   wait_done("b225", 0);
    start_op(2, 3, 1'b0);     wait_done("b3", 0);
    start_op(2, 4, 1'b0);     wait_done("b4", 0);

    for (int i = 0; i <= 17; i++) begin
      start_op(15 * i, 15 * i, 1'b0);
      wait_done($sformatf("sweep%0d", i), 0);
    end

    // Operands change and start pulses mid-operation; latched values must win.
    start_op(7, 100, 1'b0);
    @(negedge clk);
    bus.a_i = 8'd200; bus.b_i = 8'd9; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done("midop", 2);
    check("midop_idle", {31'd0, bus.busy_o}, 32'd0);

    // Start held high: a second operation begins on the edge after completion.
    start_op(3, 16, 1'b1);
    exp_q.push_back(model(3, 16));
    wait_done("hold1", 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done("hold2", 0);

    // Reset at cycle 10 of an operation aborts it.
    start_op(100, 50, 1'b0);
    repeat (8) @(negedge clk);
    check("pre_abort_busy", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    check("abort_y", {8'd0, bus.y_o}, 32'd0);
    start_op(9, 81, 1'b0);
    wait_done("after_abort", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
